// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    localparam logic [2:0] MEM_WORD_BYTES  = 3'd4;
    localparam int         DEFAULT_TIMEOUT = 4095;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin picker. req[0] = instruction port, req[1] = data port.
// On a tie the port that did not win last time is chosen; after reset the
// data port counts as the last winner, so the first tie goes to instructions.
module mem_arbiter_rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    grant_t last_grant;

    // One-hot pick from the current requests and the previous winner.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == GNT_D) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Remember the winner whenever the caller commits a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GNT_D;
        end else if (update && (grant != 2'b00)) begin
            last_grant <= grant[1] ? GNT_D : GNT_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single mem_controller request path between the instruction-fetch
// and load/store ports, inserts the mandatory start-low gap between
// transactions and aborts transactions that never complete.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_done,
    input  logic        d_req,
    input  logic        d_is_write,
    input  logic [2:0]  d_num_bytes,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        mem_start_request,
    output logic [31:0] mem_target_address,
    output logic        mem_is_write,
    output logic [2:0]  mem_num_bytes,
    output logic [31:0] mem_write_value,
    output logic        mem_is_data_fetch,
    input  logic [31:0] mem_fetched_instruction,
    input  logic [31:0] mem_fetched_data,
    input  logic        mem_request_done,
    output logic        timeout_err
);

    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    // Abort on the edge that would take the counter to TIMEOUT, so
    // start_request is high for exactly TIMEOUT cycles before giving up.
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] wd_cnt;
    logic [1:0]       gnt;
    logic             grant_en;
    logic             finish_ok;
    logic             finish_to;

    mem_arbiter_rr_arb2 u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({d_req, i_req}),
        .update (grant_en),
        .grant  (gnt)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle control strobes; completion wins over watchdog.
    always_comb begin
        state_next = state;
        grant_en   = 1'b0;
        finish_ok  = 1'b0;
        finish_to  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gnt != 2'b00) begin
                    grant_en   = 1'b1;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_request_done) begin
                    finish_ok  = 1'b1;
                    state_next = ST_GAP;
                end else if (wd_cnt == WD_LAST) begin
                    finish_to  = 1'b1;
                    state_next = ST_GAP;
                end
            end
            ST_GAP:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Command register, result latches, done pulses and watchdog counter.
    // mem_is_data_fetch doubles as the record of which port owns the
    // transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_start_request  <= 1'b0;
            mem_target_address <= '0;
            mem_is_write       <= 1'b0;
            mem_num_bytes      <= '0;
            mem_write_value    <= '0;
            mem_is_data_fetch  <= 1'b0;
            i_rdata            <= '0;
            d_rdata            <= '0;
            i_done             <= 1'b0;
            d_done             <= 1'b0;
            timeout_err        <= 1'b0;
            wd_cnt             <= '0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;

            if (grant_en) begin
                mem_start_request <= 1'b1;
                wd_cnt            <= '0;
                if (gnt[1]) begin
                    mem_target_address <= d_addr;
                    mem_is_write       <= d_is_write;
                    mem_num_bytes      <= d_num_bytes;
                    mem_write_value    <= d_wdata;
                    mem_is_data_fetch  <= 1'b1;
                end else if (gnt[0]) begin
                    mem_target_address <= i_addr;
                    mem_is_write       <= 1'b0;
                    mem_num_bytes      <= MEM_WORD_BYTES;
                    mem_write_value    <= '0;
                    mem_is_data_fetch  <= 1'b0;
                end
            end

            if (state == ST_BUSY && !finish_ok && !finish_to) begin
                wd_cnt <= wd_cnt + CNT_W'(1);
            end

            if (finish_ok || finish_to) begin
                mem_start_request <= 1'b0;
                if (mem_is_data_fetch) begin
                    d_done <= 1'b1;
                    if (finish_to) begin
                        d_rdata <= '0;
                    end else if (!mem_is_write) begin
                        d_rdata <= mem_fetched_data;
                    end
                end else begin
                    i_done  <= 1'b1;
                    i_rdata <= finish_to ? '0 : mem_fetched_instruction;
                end
            end

            if (finish_to) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule
